reg_dump: RTL and testbench

- Readout engine on the register-file read side.
- On a `go` pulse it walks a contiguous, possibly wrapping, address range by driving one combinational read port of the register file.
- Each 8-bit word is registered and streamed out over a valid/ready interface, tagged with its address.
- Used for end-of-program result dumps and debug snapshots, without stalling the core's own read ports.

---
 rtl/reg_dump.sv | 131 +++++++++++++
 tb/tb_reg_dump.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// reg_dump: walks a contiguous address range of a register file through one
// combinational read port. Each word is registered and streamed out over a
// valid/ready interface, tagged with the address it came from.
//
// Ports:
//   clk         system clock, all state updates on posedge
//   start       synchronous active-high reset, aborts any dump in flight
//   go          single-cycle dump request, only looked at in IDLE
//   first_addr  first address of the range, latched on go
//   last_addr   last address of the range (inclusive), latched on go
//   rd_addr     register-file read address (always equal to the pointer)
//   rd_data     combinational read data for rd_addr
//   dout        streamed data word
//   dout_addr   address dout was read from
//   dout_valid  dout/dout_addr hold a word
//   dout_ready  consumer accepts the word this cycle
//   busy        high while reading or draining
//   done        one-cycle pulse after the final word is accepted
//   count       words accepted in the current or most recent dump
module reg_dump #(
    parameter int pw = 4
) (
    input  logic          clk,
    input  logic          start,
    input  logic          go,
    input  logic [pw-1:0] first_addr,
    input  logic [pw-1:0] last_addr,
    output logic [pw-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    dout,
    output logic [pw-1:0] dout_addr,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          done,
    output logic [pw:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [pw-1:0] ptr;
    logic [pw:0]   remaining;
    logic [pw-1:0] span;
    logic [pw:0]   len;
    logic          xfer;
    logic          load;
    logic          accept_go;

    // The modular subtraction gives 0..2**pw-1, so len spans 1..2**pw and
    // needs the extra bit; last == first-1 therefore means a full-depth dump.
    assign span      = last_addr - first_addr;
    assign len       = {1'b0, span} + {{pw{1'b0}}, 1'b1};

    assign xfer      = dout_valid & dout_ready;
    // The output register can take a new word when it is empty or being
    // emptied this cycle; that overlap is what sustains one word per cycle.
    assign load      = (state == S_READ) & (~dout_valid | dout_ready) & (remaining != '0);
    assign accept_go = (state == S_IDLE) & go;

    assign rd_addr   = ptr;

    // State register
    always_ff @(posedge clk) begin
        if (start) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_READ;
            // Leave READ on the edge that loads the final word.
            S_READ:  if (load && remaining == {{pw{1'b0}}, 1'b1}) state_nxt = S_DRAIN;
            // Only the final word can be in the output register here.
            S_DRAIN: if (xfer) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_READ, S_DRAIN: busy = 1'b1;
            S_DONE:          done = 1'b1;
            default:         ;
        endcase
    end

    // Datapath: pointer, remaining-word counter, output register, beat count
    always_ff @(posedge clk) begin
        if (start) begin
            ptr        <= '0;
            remaining  <= '0;
            dout       <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
            count      <= '0;
        end else begin
            if (accept_go) begin
                ptr       <= first_addr;
                remaining <= len;
                count     <= '0;
            end

            if (load) begin
                dout       <= rd_data;
                dout_addr  <= ptr;
                dout_valid <= 1'b1;
                ptr        <= ptr + {{(pw-1){1'b0}}, 1'b1};
                remaining  <= remaining - {{pw{1'b0}}, 1'b1};
            end else if (xfer) begin
                dout_valid <= 1'b0;
            end

            // No transfer can happen in IDLE, so this never collides with
            // the clear on go acceptance.
            if (xfer) count <= count + {{pw{1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;

    localparam int PW    = 4;
    localparam int DEPTH = 1 << PW;

    logic          clk = 1'b0;
    logic          start;
    logic          go;
    logic [PW-1:0] first_addr;
    logic [PW-1:0] last_addr;
    logic [PW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    dout;
    logic [PW-1:0] dout_addr;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          done;
    logic [PW:0]   count;

    logic [7:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    reg_dump #(.pw(PW)) dut (
        .clk        (clk),
        .start      (start),
        .go         (go),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    // Reference: a dump of first..last visits len words, word i at address
    // (first+i) mod DEPTH carrying the memory contents at that address.
    function automatic int ref_len(input int f, input int l);
        return ((l - f + DEPTH) % DEPTH) + 1;
    endfunction

    // Issues go, then watches the stream cycle by cycle (sampling at negedge)
    // until done is seen. Beats, hold stability, done timing and count are
    // all compared against the reference.
    task automatic run_dump(input string name, input int f, input int l,
                            input int ready_pct, input bit mid_go);
        int   len, beats, last_cyc, first_cyc;
        bit   finished, hold;
        bit   rdy;
        logic [7:0]    held_d;
        logic [PW-1:0] held_a;
        int   exp_a;
        len = ref_len(f, l);
        beats = 0; last_cyc = -10; first_cyc = -1; finished = 0; hold = 0;
        held_d = '0; held_a = '0;
        @(negedge clk);
        first_addr = PW'(f); last_addr = PW'(l); go = 1'b1; dout_ready = 1'b0;
        @(negedge clk);
        go = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (done) begin
                checks++;
                if (beats !== len || last_cyc !== cyc - 1) begin
                    errors++;
                    $display("FAIL %s done_timing: beats=%0d last_beat_cyc=%0d done_cyc=%0d, required beats=%0d done one cycle after last beat",
                             name, beats, last_cyc, cyc, len);
                end
                checks++;
                if (count !== (PW+1)'(len)) begin
                    errors++;
                    $display("FAIL %s count: got %0d required %0d", name, count, len);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_at_done: got %b required 0", name, busy);
                end
                finished = 1;
            end else begin
                if (hold) begin
                    checks++;
                    if (dout_valid !== 1'b1 || dout !== held_d || dout_addr !== held_a) begin
                        errors++;
                        $display("FAIL %s hold_stable: got v=%b d=%0d a=%0d required v=1 d=%0d a=%0d",
                                 name, dout_valid, dout, dout_addr, held_d, held_a);
                    end
                end
                if (ready_pct == 100 && cyc == 1) begin
                    checks++;
                    if (dout_valid !== 1'b1 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s first_word_latency: got valid=%b busy=%b required 1 1",
                                 name, dout_valid, busy);
                    end
                end
                // Re-request with a different range mid-dump; it must be ignored.
                if (mid_go && cyc == 3) begin
                    first_addr = PW'(f + 5); last_addr = PW'(f + 6); go = 1'b1;
                end else begin
                    go = 1'b0;
                end
                rdy = ($urandom_range(99) < ready_pct);
                dout_ready = rdy;
                if (dout_valid && rdy) begin
                    exp_a = (f + beats) % DEPTH;
                    checks++;
                    if (beats >= len || dout_addr !== PW'(exp_a) || dout !== mem[exp_a]) begin
                        errors++;
                        $display("FAIL %s beat%0d: got a=%0d d=%0d required a=%0d d=%0d (len %0d)",
                                 name, beats, dout_addr, dout, exp_a, mem[exp_a], len);
                    end
                    if (first_cyc < 0) first_cyc = cyc;
                    beats++;
                    last_cyc = cyc;
                end
                hold   = dout_valid && !rdy;
                held_d = dout;
                held_a = dout_addr;
            end
            @(negedge clk);
        end
        go = 1'b0;
        dout_ready = 1'b0;
        if (!finished) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d beats and no done, required %0d beats then done", name, beats, len);
        end
        if (ready_pct == 100) begin
            checks++;
            if (last_cyc - first_cyc !== len - 1) begin
                errors++;
                $display("FAIL %s throughput: got %0d cycles between first and last beat, required %0d",
                         name, last_cyc - first_cyc, len - 1);
            end
        end
        // Done must be a single-cycle pulse.
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b busy=%b after pulse, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        start = 1'b1; go = 1'b0; dout_ready = 1'b0; first_addr = '0; last_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_addr !== '0 || dout !== '0 || dout_addr !== '0 || dout_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_state: got rd=%0d d=%0d a=%0d v=%b busy=%b done=%b cnt=%0d, required all 0",
                     rd_addr, dout, dout_addr, dout_valid, busy, done, count);
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rd_addr !== '0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: got rd=%0d v=%b busy=%b required 0 0 0", i, rd_addr, dout_valid, busy);
            end
        end
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 3);
        run_dump("full", 0, 15, 100, 0);
    endtask

    task automatic test_wrap_single();
        run_dump("wrap", 14, 1, 100, 0);
        run_dump("single", 7, 7, 100, 0);
        run_dump("full_wrap", 9, 8, 100, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        run_dump("bp_full", 0, 15, 50, 0);
        run_dump("bp_wrap", 12, 3, 50, 0);
        run_dump("bp_single", 4, 4, 30, 0);
    endtask

    task automatic test_ignored_go();
        run_dump("mid_go", 2, 10, 70, 1);
    endtask

    task automatic test_abort();
        int beats;
        bit hit;
        beats = 0; hit = 0;
        @(negedge clk);
        first_addr = 4'd0; last_addr = 4'd15; go = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
            if (dout_valid) beats++;
            if (beats == 5) hit = 1;
            @(negedge clk);
        end
        // Five beats have transferred; abort now.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (!hit || dout_valid !== 1'b0 || busy !== 1'b0 || count !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got hit=%b v=%b busy=%b cnt=%0d done=%b required 1 0 0 0 0",
                     hit, dout_valid, busy, count, done);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: got done=%b v=%b busy=%b required 0 0 0", i, done, dout_valid, busy);
            end
        end
        dout_ready = 1'b0;
        run_dump("after_abort", 3, 6, 100, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_full_dump();
        test_wrap_single();
        test_backpressure();
        test_ignored_go();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
